commit_trace_ctrl: RTL and testbench

Sequences retired-instruction records from the core's commit stage toward the simulation DPI/difftest side, which consumes one record at a time.
- Buffers records in a small FIFO and presents them over a valid/ready handshake.
- Owns the end-of-simulation sequence. On ebreak, or on a commit watchdog timeout, it stops accepting commits, drains the FIFO, then asserts a sticky halt with an exit code.

---
 rtl/npc_trace_pkg.sv | 26 ++
 rtl/trace_fifo.sv | 54 +++++
 rtl/commit_trace_ctrl.sv | 124 ++++++++++++
 tb/tb_commit_trace_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_trace_pkg.sv
// rtl/npc_trace_pkg.sv - shared types and constants for the commit trace path
package npc_trace_pkg;

    localparam int unsigned TRC_XLEN = 64;
    localparam int unsigned TRC_ILEN = 32;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        HALT  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        EBREAK  = 2'b01,
        TIMEOUT = 2'b10
    } halt_reason_e;

    typedef struct packed {
        logic [TRC_XLEN-1:0] pc;
        logic [TRC_ILEN-1:0] inst;
    } trace_rec_t;

    localparam logic [TRC_XLEN-1:0] HALT_CODE_TIMEOUT = '1;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through FIFO of trace records
module trace_fifo #(
    parameter type rec_t = npc_trace_pkg::trace_rec_t,
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  rec_t                     wr_data,
    input  logic                     pop,
    output rec_t                     rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    rec_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/commit_trace_ctrl.sv
// rtl/commit_trace_ctrl.sv - commit-to-trace sequencer with end-of-simulation control
module commit_trace_ctrl #(
    parameter int XLEN    = 64,
    parameter int ILEN    = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmt_valid,
    output logic            cmt_ready,
    input  logic [XLEN-1:0] cmt_pc,
    input  logic [ILEN-1:0] cmt_inst,
    input  logic            cmt_ebreak,
    input  logic [XLEN-1:0] cmt_a0,
    output logic            trc_valid,
    input  logic            trc_ready,
    output logic [XLEN-1:0] trc_pc,
    output logic [ILEN-1:0] trc_inst,
    output logic            halt,
    output logic [1:0]      halt_reason,
    output logic [XLEN-1:0] halt_code,
    output logic [63:0]     commit_cnt
);

    import npc_trace_pkg::*;

    localparam int WD_W = $clog2(TIMEOUT);
    localparam int CW   = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } rec_t;

    state_e          state;
    state_e          state_nx;
    halt_reason_e    reason_q;
    logic            ready_en;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    rec_t            wr_rec;
    rec_t            head;
    logic [WD_W-1:0] wd_cnt;
    logic            accept;
    logic            emit;
    logic            wd_expire;

    // ready_en keeps cmt_ready low until the first clock after reset release.
    assign cmt_ready   = ready_en && (state == RUN) && !fifo_full;
    assign trc_valid   = !fifo_empty && (state != HALT);
    assign accept      = cmt_valid && cmt_ready;
    assign emit        = trc_valid && trc_ready;
    assign wd_expire   = (state == RUN) && !accept && (wd_cnt == WD_W'(TIMEOUT - 1));
    assign wr_rec      = '{pc: cmt_pc, inst: cmt_inst};
    assign trc_pc      = head.pc;
    assign trc_inst    = head.inst;
    assign halt_reason = reason_q;

    trace_fifo #(
        .rec_t (rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (accept),
        .wr_data (wr_rec),
        .pop     (emit),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_nx = state;
        case (state)
            RUN: begin
                if ((accept && cmt_ebreak) || wd_expire) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if ((fifo_count == '0) || ((fifo_count == CW'(1)) && emit)) begin
                    state_nx = HALT;
                end
            end
            HALT:    state_nx = HALT;
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            ready_en   <= 1'b0;
            wd_cnt     <= '0;
            reason_q   <= NONE;
            halt_code  <= '0;
            halt       <= 1'b0;
            commit_cnt <= '0;
        end else begin
            state    <= state_nx;
            ready_en <= 1'b1;
            halt     <= (state_nx == HALT);
            if (emit) begin
                commit_cnt <= commit_cnt + 64'd1;
            end
            if (state == RUN) begin
                wd_cnt <= accept ? '0 : wd_cnt + 1'b1;
            end
            // An accepted ebreak outranks a coinciding watchdog expiry.
            if (state == RUN && accept && cmt_ebreak) begin
                reason_q  <= EBREAK;
                halt_code <= cmt_a0;
            end else if (wd_expire) begin
                reason_q  <= npc_trace_pkg::TIMEOUT;
                halt_code <= XLEN'(HALT_CODE_TIMEOUT);
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_ctrl.sv
// tb/tb_commit_trace_ctrl.sv - directed self-checking bench for commit_trace_ctrl
module tb_commit_trace_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmt_valid = 1'b0;
    logic        cmt_ready;
    logic [63:0] cmt_pc = '0;
    logic [31:0] cmt_inst = '0;
    logic        cmt_ebreak = 1'b0;
    logic [63:0] cmt_a0 = '0;
    logic        trc_valid;
    logic        trc_ready = 1'b0;
    logic [63:0] trc_pc;
    logic [31:0] trc_inst;
    logic        halt;
    logic [1:0]  halt_reason;
    logic [63:0] halt_code;
    logic [63:0] commit_cnt;

    int total = 0;
    int bad   = 0;

    commit_trace_ctrl #(
        .XLEN    (64),
        .ILEN    (32),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmt_valid   (cmt_valid),
        .cmt_ready   (cmt_ready),
        .cmt_pc      (cmt_pc),
        .cmt_inst    (cmt_inst),
        .cmt_ebreak  (cmt_ebreak),
        .cmt_a0      (cmt_a0),
        .trc_valid   (trc_valid),
        .trc_ready   (trc_ready),
        .trc_pc      (trc_pc),
        .trc_inst    (trc_inst),
        .halt        (halt),
        .halt_reason (halt_reason),
        .halt_code   (halt_code),
        .commit_cnt  (commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] pc_of(input int i);
        return 64'h8000_0000 + 64'(4 * i);
    endfunction

    task automatic drive(input logic [63:0] pc, input logic eb, input logic [63:0] a0);
        cmt_valid  = 1'b1;
        cmt_pc     = pc;
        cmt_inst   = 32'h0000_0013;
        cmt_ebreak = eb;
        cmt_a0     = a0;
    endtask

    task automatic idle();
        cmt_valid  = 1'b0;
        cmt_ebreak = 1'b0;
    endtask

    // Returns on the negedge where rst_n is released, before the first clock.
    task automatic do_reset();
        idle();
        trc_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // reset values
        @(negedge clk);
        check("rst_cmt_ready", 64'(cmt_ready), 64'd0);
        check("rst_trc_valid", 64'(trc_valid), 64'd0);
        check("rst_halt", 64'(halt), 64'd0);
        check("rst_reason", 64'(halt_reason), 64'd0);
        check("rst_code", halt_code, 64'd0);
        check("rst_cnt", commit_cnt, 64'd0);
        do_reset();
        check("rel_cmt_ready_lo", 64'(cmt_ready), 64'd0);

        // back-to-back stream
        trc_ready = 1'b1;
        @(negedge clk);
        check("rel_cmt_ready_hi", 64'(cmt_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            drive(pc_of(i), 1'b0, 64'd0);
            if (i > 0) begin
                check("stream_pc", trc_pc, pc_of(i - 1));
                check("stream_valid", 64'(trc_valid), 64'd1);
            end
            @(negedge clk);
        end
        idle();
        check("stream_pc_last", trc_pc, pc_of(5));
        check("stream_inst", 64'(trc_inst), 64'h13);
        @(negedge clk);
        check("stream_empty", 64'(trc_valid), 64'd0);
        check("stream_cnt", commit_cnt, 64'd6);
        check("stream_halt", 64'(halt), 64'd0);

        // backpressure with a full FIFO
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(pc_of(10 + i), 1'b0, 64'd0);
            check("bp_ready_fill", 64'(cmt_ready), 64'd1);
            @(negedge clk);
        end
        drive(pc_of(14), 1'b0, 64'd0);
        check("bp_ready_full", 64'(cmt_ready), 64'd0);
        @(negedge clk);
        check("bp_ready_full2", 64'(cmt_ready), 64'd0);
        check("bp_head_stable", trc_pc, pc_of(10));
        trc_ready = 1'b1;
        check("bp_no_passthru", 64'(cmt_ready), 64'd0);
        @(negedge clk);
        check("bp_ready_freed", 64'(cmt_ready), 64'd1);
        check("bp_pc1", trc_pc, pc_of(11));
        @(negedge clk);
        idle();
        for (int i = 2; i < 5; i++) begin
            check("bp_order", trc_pc, pc_of(10 + i));
            @(negedge clk);
        end
        check("bp_empty", 64'(trc_valid), 64'd0);
        check("bp_cnt", commit_cnt, 64'd5);

        // ebreak with free-running consumer
        do_reset();
        trc_ready = 1'b1;
        @(negedge clk);
        drive(pc_of(20), 1'b0, 64'd0);
        @(negedge clk);
        drive(pc_of(21), 1'b0, 64'd0);
        check("eb_pc0", trc_pc, pc_of(20));
        @(negedge clk);
        drive(pc_of(22), 1'b1, 64'd0);
        check("eb_pc1", trc_pc, pc_of(21));
        @(negedge clk);
        drive(64'hdead_0000, 1'b0, 64'd7);
        check("eb_ready_lo", 64'(cmt_ready), 64'd0);
        check("eb_reason", 64'(halt_reason), 64'd1);
        check("eb_halt_lo", 64'(halt), 64'd0);
        check("eb_last_rec", trc_pc, pc_of(22));
        @(negedge clk);
        check("eb_halt", 64'(halt), 64'd1);
        check("eb_code", halt_code, 64'd0);
        check("eb_cnt", commit_cnt, 64'd3);
        check("eb_trc_valid", 64'(trc_valid), 64'd0);
        repeat (2) @(negedge clk);
        check("eb_ignored_cnt", commit_cnt, 64'd3);
        check("eb_ignored_valid", 64'(trc_valid), 64'd0);
        check("eb_sticky", 64'(halt), 64'd1);
        idle();

        // bad trap while the consumer stalls
        do_reset();
        @(negedge clk);
        drive(pc_of(30), 1'b1, 64'd1);
        @(negedge clk);
        idle();
        check("bt_reason", 64'(halt_reason), 64'd1);
        check("bt_code_early", halt_code, 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("bt_halt_lo", 64'(halt), 64'd0);
            check("bt_valid", 64'(trc_valid), 64'd1);
            @(negedge clk);
        end
        trc_ready = 1'b1;
        @(negedge clk);
        check("bt_halt", 64'(halt), 64'd1);
        check("bt_code", halt_code, 64'd1);
        check("bt_cnt", commit_cnt, 64'd1);

        // watchdog with no commits
        do_reset();
        repeat (15) @(negedge clk);
        check("wd_reason_15", 64'(halt_reason), 64'd0);
        @(negedge clk);
        check("wd_reason_16", 64'(halt_reason), 64'd2);
        check("wd_halt_16", 64'(halt), 64'd0);
        check("wd_ready_16", 64'(cmt_ready), 64'd0);
        @(negedge clk);
        check("wd_halt_17", 64'(halt), 64'd1);
        check("wd_code", halt_code, 64'hffff_ffff_ffff_ffff);

        // watchdog rescued by a commit at the expiry cycle
        do_reset();
        trc_ready = 1'b1;
        repeat (15) @(negedge clk);
        drive(pc_of(40), 1'b0, 64'd0);
        @(negedge clk);
        idle();
        check("wdr_reason", 64'(halt_reason), 64'd0);
        check("wdr_ready", 64'(cmt_ready), 64'd1);
        repeat (15) @(negedge clk);
        check("wdr_reason_restart", 64'(halt_reason), 64'd0);
        @(negedge clk);
        check("wdr_reason_late", 64'(halt_reason), 64'd2);
        @(negedge clk);
        check("wdr_halt", 64'(halt), 64'd1);
        check("wdr_cnt", commit_cnt, 64'd1);

        // asynchronous reset during drain
        do_reset();
        @(negedge clk);
        drive(pc_of(50), 1'b0, 64'd0);
        @(negedge clk);
        drive(pc_of(51), 1'b1, 64'd5);
        @(negedge clk);
        idle();
        check("rd_reason_pre", 64'(halt_reason), 64'd1);
        check("rd_head_pre", trc_pc, pc_of(50));
        #2 rst_n = 1'b0;
        #1;
        check("rd_valid", 64'(trc_valid), 64'd0);
        check("rd_ready", 64'(cmt_ready), 64'd0);
        check("rd_reason", 64'(halt_reason), 64'd0);
        check("rd_code", halt_code, 64'd0);
        check("rd_halt", 64'(halt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        trc_ready = 1'b1;
        @(negedge clk);
        drive(64'h9000_0000, 1'b0, 64'd0);
        @(negedge clk);
        idle();
        check("rd_new_pc", trc_pc, 64'h9000_0000);
        @(negedge clk);
        check("rd_new_cnt", commit_cnt, 64'd1);
        check("rd_new_empty", 64'(trc_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
